// File: rtl/multicycle_control_fsm.sv
// Multi-cycle LEGv8 control sequencer: fetch/decode/execute/memory/writeback with
// variable-latency memory handshakes, retire counting and a sticky fault trap.
module multicycle_control_fsm #(
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Start,
   input  logic             Stop,
   input  logic [10:0]      Opcode,
   input  logic             Zero,
   input  logic             Imem_ready,
   input  logic             Dmem_ready,
   output logic             Reg2Loc,
   output logic             ALUSrc,
   output logic [1:0]       ALUOp,
   output logic             MemtoReg,
   output logic             RegWrite,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             InstrRead,
   output logic             IRWrite,
   output logic             PCWrite,
   output logic             Branch,
   output logic             UncondBranch,
   output logic             Busy,
   output logic             Illegal,
   output logic [CNT_W-1:0] Instr_count
);

   typedef enum logic [2:0] {
      StIdle, StFetch, StDecode, StExec, StMem, StWb, StFault
   } state_e;

   typedef enum logic [2:0] {
      ClsNone, ClsR, ClsLdur, ClsStur, ClsCbz, ClsB, ClsIllegal
   } cls_e;

   localparam logic [7:0] WaitLast = 8'(MAX_WAIT - 1);

   state_e           state_q, state_d;
   cls_e             cls_q, cls_d;
   cls_e             dec_cls, cls_eff;
   logic [7:0]       wait_q, wait_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             retire;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         cls_q   <= ClsNone;
         wait_q  <= 8'd0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         wait_q  <= wait_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      dec_cls = ClsIllegal;
      casez (Opcode)
         11'b10001011000, 11'b11001011000,
         11'b10001010000, 11'b10101010000: dec_cls = ClsR;
         11'b11111000010:                  dec_cls = ClsLdur;
         11'b11111000000:                  dec_cls = ClsStur;
         11'b10110100???:                  dec_cls = ClsCbz;
         11'b000101?????:                  dec_cls = ClsB;
         default:                          dec_cls = ClsIllegal;
      endcase
   end

   // The class is not latched until the end of DECODE, so DECODE uses the live decode.
   assign cls_eff = (state_q == StDecode) ? dec_cls : cls_q;

   always_comb begin
      retire = 1'b0;
      unique case (state_q)
         StExec:  retire = (cls_q == ClsCbz) || (cls_q == ClsB);
         StMem:   retire = (cls_q == ClsStur) && Dmem_ready;
         StWb:    retire = 1'b1;
         default: retire = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      unique case (state_q)
         StIdle: begin
            if (Start && !Stop) state_d = StFetch;
         end
         StFetch: begin
            if (Imem_ready)             state_d = StDecode;
            else if (wait_q == WaitLast) state_d = StFault;
         end
         StDecode: begin
            cls_d   = dec_cls;
            state_d = (dec_cls == ClsIllegal) ? StFault : StExec;
         end
         StExec: begin
            unique case (cls_q)
               ClsR:             state_d = StWb;
               ClsLdur, ClsStur: state_d = StMem;
               ClsCbz, ClsB:     state_d = StExec;
               default:          state_d = StFault;
            endcase
         end
         StMem: begin
            if (Dmem_ready) begin
               if (cls_q == ClsLdur) state_d = StWb;
            end else if (wait_q == WaitLast) begin
               state_d = StFault;
            end
         end
         StWb:    state_d = StWb;
         StFault: state_d = StFault;
         default: state_d = StIdle;
      endcase
      if (retire) state_d = Stop ? StIdle : StFetch;
   end

   // Counts consecutive not-ready cycles; any state change restarts it.
   always_comb begin
      wait_d = 8'd0;
      if ((state_d == state_q) && ((state_q == StFetch) || (state_q == StMem))) begin
         wait_d = wait_q + 8'd1;
      end
   end

   assign count_d     = retire ? count_q + CNT_W'(1) : count_q;
   assign Instr_count = count_q;

   always_comb begin
      Reg2Loc      = 1'b0;
      ALUSrc       = 1'b0;
      ALUOp        = 2'b00;
      MemtoReg     = 1'b0;
      RegWrite     = 1'b0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      InstrRead    = 1'b0;
      IRWrite      = 1'b0;
      PCWrite      = 1'b0;
      Branch       = 1'b0;
      UncondBranch = 1'b0;
      Busy         = 1'b0;
      Illegal      = 1'b0;
      unique case (state_q)
         StFetch: begin
            Busy      = 1'b1;
            InstrRead = 1'b1;
            IRWrite   = Imem_ready;
         end
         StDecode, StExec, StMem, StWb: begin
            Busy    = 1'b1;
            Reg2Loc = (cls_eff == ClsStur) || (cls_eff == ClsCbz);
            PCWrite = retire;
            if (state_q == StExec) begin
               unique case (cls_q)
                  ClsR: ALUOp = 2'b10;
                  ClsLdur, ClsStur: ALUSrc = 1'b1;
                  ClsCbz: begin
                     ALUOp  = 2'b01;
                     Branch = Zero;
                  end
                  ClsB:    UncondBranch = 1'b1;
                  default: ALUOp = 2'b00;
               endcase
            end
            if (state_q == StMem) begin
               MemRead  = (cls_q == ClsLdur);
               MemWrite = (cls_q == ClsStur);
            end
            if (state_q == StWb) begin
               RegWrite = 1'b1;
               MemtoReg = (cls_q == ClsLdur);
            end
         end
         StFault: Illegal = 1'b1;
         default: Busy = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: a CNT_W=16 instance plus a CNT_W=2
// instance on the same stimulus, checked against hand-computed output vectors.
module tb_multicycle_control_fsm;

   // Output vector bit map
   localparam logic [14:0] R2L  = 15'h4000;
   localparam logic [14:0] ASRC = 15'h2000;
   localparam logic [14:0] AOPR = 15'h1000;
   localparam logic [14:0] AOPB = 15'h0800;
   localparam logic [14:0] M2R  = 15'h0400;
   localparam logic [14:0] RW   = 15'h0200;
   localparam logic [14:0] MR   = 15'h0100;
   localparam logic [14:0] MW   = 15'h0080;
   localparam logic [14:0] IRD  = 15'h0040;
   localparam logic [14:0] IRW  = 15'h0020;
   localparam logic [14:0] PCW  = 15'h0010;
   localparam logic [14:0] BR   = 15'h0008;
   localparam logic [14:0] UB   = 15'h0004;
   localparam logic [14:0] BSY  = 15'h0002;
   localparam logic [14:0] ILL  = 15'h0001;

   localparam logic [10:0] OpAdd  = 11'b10001011000;
   localparam logic [10:0] OpStur = 11'b11111000000;
   localparam logic [10:0] OpLdur = 11'b11111000010;
   localparam logic [10:0] OpCbz  = 11'b10110100101;
   localparam logic [10:0] OpB    = 11'b00010111111;
   localparam logic [10:0] OpBad  = 11'b11111111111;

   logic        clk, reset, Start, Stop, Zero, Imem_ready, Dmem_ready;
   logic [10:0] Opcode;
   logic        r2l, asrc, m2r, rw, mr, mw, ird, irw, pcw, br, ub, bsy, ill;
   logic [1:0]  aop;
   logic [15:0] count;
   logic        e_r2l, e_asrc, e_m2r, e_rw, e_mr, e_mw, e_ird, e_irw, e_pcw, e_br, e_ub;
   logic        e_bsy, e_ill;
   logic [1:0]  e_aop;
   logic [1:0]  count2;
   logic [14:0] outs, outs2;
   int          n_run, n_fail;

   multicycle_control_fsm dut (
      .clk(clk), .reset(reset), .Start(Start), .Stop(Stop), .Opcode(Opcode), .Zero(Zero),
      .Imem_ready(Imem_ready), .Dmem_ready(Dmem_ready), .Reg2Loc(r2l), .ALUSrc(asrc),
      .ALUOp(aop), .MemtoReg(m2r), .RegWrite(rw), .MemRead(mr), .MemWrite(mw),
      .InstrRead(ird), .IRWrite(irw), .PCWrite(pcw), .Branch(br), .UncondBranch(ub),
      .Busy(bsy), .Illegal(ill), .Instr_count(count)
   );

   multicycle_control_fsm #(.CNT_W(2), .MAX_WAIT(15)) dut2 (
      .clk(clk), .reset(reset), .Start(Start), .Stop(Stop), .Opcode(Opcode), .Zero(Zero),
      .Imem_ready(Imem_ready), .Dmem_ready(Dmem_ready), .Reg2Loc(e_r2l), .ALUSrc(e_asrc),
      .ALUOp(e_aop), .MemtoReg(e_m2r), .RegWrite(e_rw), .MemRead(e_mr), .MemWrite(e_mw),
      .InstrRead(e_ird), .IRWrite(e_irw), .PCWrite(e_pcw), .Branch(e_br), .UncondBranch(e_ub),
      .Busy(e_bsy), .Illegal(e_ill), .Instr_count(count2)
   );

   assign outs  = {r2l, asrc, aop, m2r, rw, mr, mw, ird, irw, pcw, br, ub, bsy, ill};
   assign outs2 = {e_r2l, e_asrc, e_aop, e_m2r, e_rw, e_mr, e_mw, e_ird, e_irw, e_pcw,
                   e_br, e_ub, e_bsy, e_ill};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_o(input string tag, input logic [14:0] exp);
      chk(tag, {17'd0, outs}, {17'd0, exp});
      chk({tag, "_w2"}, {17'd0, outs2}, {17'd0, exp});
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_run = 0;
      n_fail = 0;
      reset = 1'b1; Start = 1'b0; Stop = 1'b0; Opcode = '0; Zero = 1'b0;
      Imem_ready = 1'b0; Dmem_ready = 1'b0;
      #3;
      chk_o("reset_outs", '0);
      chk("reset_cnt", {16'd0, count}, 32'd0);
      @(negedge clk) reset = 1'b0;
      #1;

      // Start together with Stop keeps IDLE
      Start = 1'b1; Stop = 1'b1;
      cyc; #1 chk_o("idle_start_stop", '0);

      // ADD with immediate memory
      Opcode = OpAdd; Imem_ready = 1'b1; Stop = 1'b0;
      cyc; Start = 1'b0; #1 chk_o("add_fetch", IRD | IRW | BSY);
      cyc; #1 chk_o("add_decode", BSY);
      cyc; #1 chk_o("add_exec", AOPR | BSY);
      cyc; Stop = 1'b1; #1 chk_o("add_wb", RW | PCW | BSY);
      chk("add_cnt_pre", {16'd0, count}, 32'd0);
      cyc; #1 chk_o("add_idle", '0);
      chk("add_cnt", {16'd0, count}, 32'd1);

      // STUR, data memory ready on the third MEM cycle
      Opcode = OpStur; Stop = 1'b0; Start = 1'b1;
      cyc; Start = 1'b0; #1 chk_o("stur_fetch", IRD | IRW | BSY);
      cyc; #1 chk_o("stur_decode", R2L | BSY);
      cyc; #1 chk_o("stur_exec", R2L | ASRC | BSY);
      cyc; #1 chk_o("stur_mem1", R2L | MW | BSY);
      cyc; #1 chk_o("stur_mem2", R2L | MW | BSY);
      cyc; Dmem_ready = 1'b1; Stop = 1'b1; #1 chk_o("stur_mem3", R2L | MW | PCW | BSY);
      cyc; Dmem_ready = 1'b0; #1 chk_o("stur_idle", '0);
      chk("stur_cnt", {16'd0, count}, 32'd2);

      // CBZ taken then not taken, back to back
      Opcode = OpCbz; Stop = 1'b0; Start = 1'b1;
      cyc; Start = 1'b0; #1 chk_o("cbz_fetch", IRD | IRW | BSY);
      cyc; #1 chk_o("cbz_decode", R2L | BSY);
      cyc; Zero = 1'b1; #1 chk_o("cbz_exec_taken", R2L | AOPB | PCW | BR | BSY);
      cyc; Zero = 1'b0; #1 chk_o("cbz_refetch", IRD | IRW | BSY);
      chk("cbz_cnt1", {16'd0, count}, 32'd3);
      cyc; #1 chk_o("cbz_decode2", R2L | BSY);
      cyc; Stop = 1'b1; #1 chk_o("cbz_exec_nt", R2L | AOPB | PCW | BSY);
      cyc; #1 chk_o("cbz_idle", '0);
      chk("cbz_cnt2", {16'd0, count}, 32'd4);
      chk("cbz_cnt_w2", {30'd0, count2}, 32'd0);

      // Unconditional B
      Opcode = OpB; Stop = 1'b0; Start = 1'b1;
      cyc; Start = 1'b0; #1 chk_o("b_fetch", IRD | IRW | BSY);
      cyc; #1 chk_o("b_decode", BSY);
      cyc; Stop = 1'b1; #1 chk_o("b_exec", PCW | UB | BSY);
      cyc; #1 chk_o("b_idle", '0);
      chk("b_cnt", {16'd0, count}, 32'd5);
      chk("b_cnt_w2_wrap", {30'd0, count2}, 32'd1);

      // LDUR interrupted by reset in MEM, then rerun to completion
      Opcode = OpLdur; Stop = 1'b0; Start = 1'b1;
      cyc; Start = 1'b0; #1 chk_o("ldur_fetch", IRD | IRW | BSY);
      cyc; #1 chk_o("ldur_decode", BSY);
      cyc; #1 chk_o("ldur_exec", ASRC | BSY);
      cyc; #1 chk_o("ldur_mem", MR | BSY);
      #1 reset = 1'b1;
      #1 chk_o("ldur_reset_outs", '0);
      chk("ldur_reset_cnt", {16'd0, count}, 32'd0);
      chk("ldur_reset_cnt_w2", {30'd0, count2}, 32'd0);
      @(negedge clk) reset = 1'b0;
      Start = 1'b1; Stop = 1'b0;
      #1 chk_o("ldur_idle_after_reset", '0);
      cyc; Start = 1'b0; #1 chk_o("ldur2_fetch", IRD | IRW | BSY);
      cyc; #1 chk_o("ldur2_decode", BSY);
      cyc; #1 chk_o("ldur2_exec", ASRC | BSY);
      cyc; Dmem_ready = 1'b1; #1 chk_o("ldur2_mem", MR | BSY);
      cyc; Dmem_ready = 1'b0; Stop = 1'b1; #1 chk_o("ldur2_wb", M2R | RW | PCW | BSY);
      cyc; #1 chk_o("ldur2_idle", '0);
      chk("ldur2_cnt", {16'd0, count}, 32'd1);

      // Instruction memory never ready: FAULT after 15 waiting cycles
      Imem_ready = 1'b0; Stop = 1'b0; Start = 1'b1;
      cyc; Start = 1'b0; #1 chk_o("to_fetch_first", IRD | BSY);
      for (int i = 0; i < 14; i++) cyc;
      #1 chk_o("to_fetch_last", IRD | BSY);
      cyc; #1 chk_o("to_fault", ILL);
      chk("to_cnt", {16'd0, count}, 32'd1);
      reset = 1'b1;
      #1 chk_o("to_reset", '0);
      @(negedge clk) reset = 1'b0;

      // Illegal opcode traps after DECODE and ignores Start
      Opcode = OpBad; Imem_ready = 1'b1; Start = 1'b1;
      cyc; Start = 1'b0; #1 chk_o("ill_fetch", IRD | IRW | BSY);
      cyc; #1 chk_o("ill_decode", BSY);
      cyc; #1 chk_o("ill_fault", ILL);
      Start = 1'b1; Opcode = OpAdd;
      for (int i = 0; i < 3; i++) cyc;
      #1 chk_o("ill_sticky", ILL);
      chk("ill_cnt", {16'd0, count}, 32'd0);
      reset = 1'b1;
      #1 chk_o("ill_reset", '0);
      Start = 1'b0;
      @(negedge clk) reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
